// File: rtl/cpu_du_link_pipe.sv
// ---------------------------------------------------------------------------
// cpu_du_link_pipe
//   Pipelined boundary between the CPU core and the debug unit. It carries two
//   independent valid/ready payload channels, each built from N_STAGES skid
//   buffers, and two fixed-latency sideband shift pipes.
//
//   Optional macro: CPU_DU_LINK_PARITY_EN
//     When defined, every payload word carries an even-parity bit through all
//     stages, and the sticky o_parity_err flag reports a delivered word that
//     fails the check. When undefined, no parity is stored and the port is
//     absent.
//
//   Ports:
//     clk, i_rst_n (async, active-low), i_flush (sync flush of both channels)
//     forward channel : i_fwd_data/i_fwd_valid/o_fwd_ready  (CPU side)
//                       o_fwd_data/o_fwd_valid/i_fwd_ready  (DU side)
//     reverse channel : i_rev_data/i_rev_valid/o_rev_ready  (DU side)
//                       o_rev_data/o_rev_valid/i_rev_ready  (CPU side)
//     sideband        : i_sb_fwd -> o_sb_fwd, i_sb_rev -> o_sb_rev (N_STAGES delay)
//     occupancy       : o_fwd_cnt, o_rev_cnt (words held per channel)
//     o_parity_err    : sticky parity error (CPU_DU_LINK_PARITY_EN only)
// ---------------------------------------------------------------------------

// One skid-buffered stage. Ready toward the source is the registered
// "skid empty" flag, so no combinational ready path crosses the stage.
module cpu_du_link_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         acc, take;

  assign o_ready = ~skid_vld_q;
  assign o_valid = main_vld_q;
  assign o_data  = main_q;
  assign acc     = i_valid & ~skid_vld_q;
  assign take    = main_vld_q & i_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (i_flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // Full: never accepts; a take promotes the skid word into main.
      if (take) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (acc && main_vld_q && !take) begin
      skid_d     = i_data;
      skid_vld_d = 1'b1;
    end else if (acc) begin
      main_d     = i_data;
      main_vld_d = 1'b1;
    end else if (take) begin
      main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end
endmodule

// One payload channel: N_STAGES chained skid stages plus occupancy counter.
module cpu_du_link_chan #(
  parameter int NB       = 32,
  parameter int N_STAGES = 2,
  parameter int NB_CNT   = 4
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic [NB-1:0]     i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [NB-1:0]     o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [NB_CNT-1:0] o_cnt
`ifdef CPU_DU_LINK_PARITY_EN
  ,
  output logic              o_parity_err
`endif
);
`ifdef CPU_DU_LINK_PARITY_EN
  localparam int SW = NB + 1;
`else
  localparam int SW = NB;
`endif

  logic [SW-1:0]     stg_data [N_STAGES+1];
  logic              stg_vld  [N_STAGES+1];
  logic              stg_rdy  [N_STAGES+1];
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic              acc, dlv;

`ifdef CPU_DU_LINK_PARITY_EN
  // Even parity: the appended bit makes the XOR of the whole word zero.
  assign stg_data[0] = {^i_data, i_data};
`else
  assign stg_data[0] = i_data;
`endif
  assign stg_vld[0]        = i_valid;
  assign o_ready           = stg_rdy[0];
  assign o_data            = stg_data[N_STAGES][NB-1:0];
  assign o_valid           = stg_vld[N_STAGES];
  assign stg_rdy[N_STAGES] = i_ready;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stg
    cpu_du_link_stage #(.W(SW)) u_stg (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_flush),
      .i_data  (stg_data[k]),
      .i_valid (stg_vld[k]),
      .o_ready (stg_rdy[k]),
      .o_data  (stg_data[k+1]),
      .o_valid (stg_vld[k+1]),
      .i_ready (stg_rdy[k+1])
    );
  end

  assign acc   = i_valid & stg_rdy[0];
  assign dlv   = stg_vld[N_STAGES] & i_ready;
  assign o_cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_flush) cnt_d = '0;
    else         cnt_d = cnt_q + NB_CNT'(acc) - NB_CNT'(dlv);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

`ifdef CPU_DU_LINK_PARITY_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (i_flush)                          err_d = 1'b0;
    else if (dlv && ^stg_data[N_STAGES])  err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign o_parity_err = err_q;
`endif
endmodule

module cpu_du_link_pipe #(
  parameter int NB_FWD   = 32,
  parameter int NB_REV   = 32,
  parameter int N_STAGES = 2,
  parameter int NB_SB    = 8,
  parameter int NB_CNT   = 4
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic [NB_FWD-1:0] i_fwd_data,
  input  logic              i_fwd_valid,
  output logic              o_fwd_ready,
  output logic [NB_FWD-1:0] o_fwd_data,
  output logic              o_fwd_valid,
  input  logic              i_fwd_ready,
  input  logic [NB_REV-1:0] i_rev_data,
  input  logic              i_rev_valid,
  output logic              o_rev_ready,
  output logic [NB_REV-1:0] o_rev_data,
  output logic              o_rev_valid,
  input  logic              i_rev_ready,
  input  logic [NB_SB-1:0]  i_sb_fwd,
  output logic [NB_SB-1:0]  o_sb_fwd,
  input  logic [NB_SB-1:0]  i_sb_rev,
  output logic [NB_SB-1:0]  o_sb_rev,
  output logic [NB_CNT-1:0] o_fwd_cnt,
  output logic [NB_CNT-1:0] o_rev_cnt
`ifdef CPU_DU_LINK_PARITY_EN
  ,
  output logic              o_parity_err
`endif
);
`ifdef CPU_DU_LINK_PARITY_EN
  logic fwd_perr, rev_perr;
  assign o_parity_err = fwd_perr | rev_perr;
`endif

  cpu_du_link_chan #(.NB(NB_FWD), .N_STAGES(N_STAGES), .NB_CNT(NB_CNT)) u_fwd (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_flush      (i_flush),
    .i_data       (i_fwd_data),
    .i_valid      (i_fwd_valid),
    .o_ready      (o_fwd_ready),
    .o_data       (o_fwd_data),
    .o_valid      (o_fwd_valid),
    .i_ready      (i_fwd_ready),
`ifdef CPU_DU_LINK_PARITY_EN
    .o_parity_err (fwd_perr),
`endif
    .o_cnt        (o_fwd_cnt)
  );

  cpu_du_link_chan #(.NB(NB_REV), .N_STAGES(N_STAGES), .NB_CNT(NB_CNT)) u_rev (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_flush      (i_flush),
    .i_data       (i_rev_data),
    .i_valid      (i_rev_valid),
    .o_ready      (o_rev_ready),
    .o_data       (o_rev_data),
    .o_valid      (o_rev_valid),
    .i_ready      (i_rev_ready),
`ifdef CPU_DU_LINK_PARITY_EN
    .o_parity_err (rev_perr),
`endif
    .o_cnt        (o_rev_cnt)
  );

  // Sideband levels: plain shift pipes matching the payload latency; flush
  // and payload stalls do not touch them.
  logic [NB_SB-1:0] sb_fwd_q [N_STAGES];
  logic [NB_SB-1:0] sb_rev_q [N_STAGES];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_STAGES; k++) begin
        sb_fwd_q[k] <= '0;
        sb_rev_q[k] <= '0;
      end
    end else begin
      sb_fwd_q[0] <= i_sb_fwd;
      sb_rev_q[0] <= i_sb_rev;
      for (int k = 1; k < N_STAGES; k++) begin
        sb_fwd_q[k] <= sb_fwd_q[k-1];
        sb_rev_q[k] <= sb_rev_q[k-1];
      end
    end
  end

  assign o_sb_fwd = sb_fwd_q[N_STAGES-1];
  assign o_sb_rev = sb_rev_q[N_STAGES-1];
endmodule

// File: tb/tb_cpu_du_link_pipe.sv
// ---------------------------------------------------------------------------
// tb_cpu_du_link_pipe
//   Self-checking bench for cpu_du_link_pipe (N_STAGES = 2). Directed checks
//   for reset, streaming latency, capacity, flush and asynchronous reset, then
//   randomized traffic on both channels against a queue-based reference.
// ---------------------------------------------------------------------------
module tb_cpu_du_link_pipe;
  localparam int NB_FWD   = 32;
  localparam int NB_REV   = 32;
  localparam int N_STAGES = 2;
  localparam int NB_SB    = 8;
  localparam int NB_CNT   = 4;
  localparam int CAP      = 2 * N_STAGES;

  logic              clk;
  logic              i_rst_n;
  logic              i_flush;
  logic [NB_FWD-1:0] i_fwd_data;
  logic              i_fwd_valid;
  logic              o_fwd_ready;
  logic [NB_FWD-1:0] o_fwd_data;
  logic              o_fwd_valid;
  logic              i_fwd_ready;
  logic [NB_REV-1:0] i_rev_data;
  logic              i_rev_valid;
  logic              o_rev_ready;
  logic [NB_REV-1:0] o_rev_data;
  logic              o_rev_valid;
  logic              i_rev_ready;
  logic [NB_SB-1:0]  i_sb_fwd;
  logic [NB_SB-1:0]  o_sb_fwd;
  logic [NB_SB-1:0]  i_sb_rev;
  logic [NB_SB-1:0]  o_sb_rev;
  logic [NB_CNT-1:0] o_fwd_cnt;
  logic [NB_CNT-1:0] o_rev_cnt;
`ifdef CPU_DU_LINK_PARITY_EN
  logic              o_parity_err;
`endif

  cpu_du_link_pipe #(
    .NB_FWD(NB_FWD), .NB_REV(NB_REV), .N_STAGES(N_STAGES),
    .NB_SB(NB_SB), .NB_CNT(NB_CNT)
  ) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_flush      (i_flush),
    .i_fwd_data   (i_fwd_data),
    .i_fwd_valid  (i_fwd_valid),
    .o_fwd_ready  (o_fwd_ready),
    .o_fwd_data   (o_fwd_data),
    .o_fwd_valid  (o_fwd_valid),
    .i_fwd_ready  (i_fwd_ready),
    .i_rev_data   (i_rev_data),
    .i_rev_valid  (i_rev_valid),
    .o_rev_ready  (o_rev_ready),
    .o_rev_data   (o_rev_data),
    .o_rev_valid  (o_rev_valid),
    .i_rev_ready  (i_rev_ready),
    .i_sb_fwd     (i_sb_fwd),
    .o_sb_fwd     (o_sb_fwd),
    .i_sb_rev     (i_sb_rev),
    .o_sb_rev     (o_sb_rev),
`ifdef CPU_DU_LINK_PARITY_EN
    .o_parity_err (o_parity_err),
`endif
    .o_fwd_cnt    (o_fwd_cnt),
    .o_rev_cnt    (o_rev_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          sent, acc_n, first_acc, first_vld, last_rx;
  bit          seen;
  logic [31:0] got [$];
  logic        fv, rv;
  logic [31:0] fd, rd;
  bit          f_acc, r_acc;
  logic [31:0] fq [$];
  logic [31:0] rq [$];
  logic [7:0]  sbf_h [$];
  logic [7:0]  sbr_h [$];
`ifdef CPU_DU_LINK_PARITY_EN
  logic [32:0] ptmp;
`endif

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0;
    i_fwd_data = '0; i_fwd_valid = 1'b0; i_fwd_ready = 1'b0;
    i_rev_data = '0; i_rev_valid = 1'b0; i_rev_ready = 1'b0;
    i_sb_fwd = '0; i_sb_rev = '0;
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    tick();

    // ---- reset / idle state
    chk("rst_fwd_ready", o_fwd_ready, 1);
    chk("rst_rev_ready", o_rev_ready, 1);
    chk("rst_fwd_valid", o_fwd_valid, 0);
    chk("rst_rev_valid", o_rev_valid, 0);
    chk("rst_fwd_cnt",   o_fwd_cnt, 0);
    chk("rst_rev_cnt",   o_rev_cnt, 0);
    chk("rst_fwd_data",  o_fwd_data, 0);
    chk("rst_sb_fwd",    o_sb_fwd, 0);

    // ---- streaming with sink always ready
    i_fwd_ready = 1'b1;
    sent = 1; first_acc = -1; first_vld = -1; last_rx = -1;
    got.delete();
    for (int c = 0; c < 60; c++) begin
      if (o_fwd_valid) begin
        if (first_vld < 0) first_vld = c;
        got.push_back(o_fwd_data);
        last_rx = c;
      end
      i_fwd_valid = (sent <= 16);
      i_fwd_data  = sent;
      if (i_fwd_valid && o_fwd_ready) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      tick();
    end
    i_fwd_valid = 1'b0;
    chk("stream_latency", first_vld - first_acc, N_STAGES);
    chk("stream_count", got.size(), 16);
    chk("stream_rate", last_rx - first_vld, 15);
    for (int i = 0; i < got.size() && i < 16; i++)
      chk("stream_order", got[i], i + 1);

    // ---- capacity with stalled sink
    i_fwd_ready = 1'b0; i_fwd_valid = 1'b1;
    sent = 1; acc_n = 0;
    for (int c = 0; c < 12; c++) begin
      i_fwd_data = sent;
      if (o_fwd_ready) begin acc_n++; sent++; end
      tick();
    end
    chk("stall_accepted", acc_n, CAP);
    chk("stall_cnt", o_fwd_cnt, CAP);
    chk("stall_ready", o_fwd_ready, 0);
    chk("stall_head", o_fwd_data, 1);
    chk("stall_rev_ready", o_rev_ready, 1);
    i_fwd_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      if (o_fwd_valid) got.push_back(o_fwd_data);
      i_fwd_data = sent;
      if (o_fwd_ready) sent++;
      tick();
    end
    chk("release_count_ge8", got.size() >= 8, 1);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("release_order", got[i], i + 1);
    i_fwd_valid = 1'b0;
    repeat (10) tick();
    chk("drain_cnt", o_fwd_cnt, 0);

    // ---- flush with 3 words held
    i_fwd_ready = 1'b0; i_fwd_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      i_fwd_data = 32'h100 + k;
      tick();
    end
    i_fwd_valid = 1'b0;
    chk("pre_flush_cnt", o_fwd_cnt, 3);
    i_flush = 1'b1; i_fwd_valid = 1'b1; i_fwd_data = 32'hDEAD; i_sb_fwd = 8'hA5;
    tick();
    i_flush = 1'b0; i_fwd_valid = 1'b0; i_sb_fwd = 8'h00;
    chk("flush_valid", o_fwd_valid, 0);
    chk("flush_cnt", o_fwd_cnt, 0);
    chk("flush_ready", o_fwd_ready, 1);
    tick();
    chk("flush_sb", o_sb_fwd, 8'hA5);
    i_fwd_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (o_fwd_valid) seen = 1'b1;
      tick();
    end
    chk("flush_no_deliver", seen, 0);

    // ---- randomized traffic on both channels
    fv = 1'b0; rv = 1'b0; fd = '0; rd = '0; f_acc = 1'b0; r_acc = 1'b0;
    fq.delete(); rq.delete(); sbf_h.delete(); sbr_h.delete();
    for (int k = 0; k < N_STAGES; k++) begin
      sbf_h.push_back(i_sb_fwd);
      sbr_h.push_back(i_sb_rev);
    end
    for (int c = 0; c < 10000; c++) begin
      chk("rnd_fwd_cnt", o_fwd_cnt, fq.size());
      chk("rnd_rev_cnt", o_rev_cnt, rq.size());
      chk("rnd_fwd_cap", o_fwd_cnt <= CAP, 1);
      chk("rnd_sb_fwd", o_sb_fwd, sbf_h.pop_front());
      chk("rnd_sb_rev", o_sb_rev, sbr_h.pop_front());
      if (!fv || f_acc) begin fv = ($urandom_range(0, 99) < 60); fd = $urandom; end
      if (!rv || r_acc) begin rv = ($urandom_range(0, 99) < 70); rd = $urandom; end
      i_fwd_valid = fv; i_fwd_data = fd;
      i_rev_valid = rv; i_rev_data = rd;
      i_fwd_ready = ($urandom_range(0, 99) < 50);
      i_rev_ready = ($urandom_range(0, 99) < 40);
      i_sb_fwd = 8'($urandom); i_sb_rev = 8'($urandom);
      sbf_h.push_back(i_sb_fwd);
      sbr_h.push_back(i_sb_rev);
      f_acc = fv && o_fwd_ready;
      r_acc = rv && o_rev_ready;
      if (o_fwd_valid && fq.size() == 0) chk("rnd_fwd_spurious", o_fwd_valid, 0);
      else if (o_fwd_valid && i_fwd_ready) chk("rnd_fwd_data", o_fwd_data, fq.pop_front());
      if (o_rev_valid && rq.size() == 0) chk("rnd_rev_spurious", o_rev_valid, 0);
      else if (o_rev_valid && i_rev_ready) chk("rnd_rev_data", o_rev_data, rq.pop_front());
      if (f_acc) fq.push_back(fd);
      if (r_acc) rq.push_back(rd);
      tick();
    end
    i_fwd_valid = 1'b0; i_rev_valid = 1'b0;
    i_fwd_ready = 1'b1; i_rev_ready = 1'b1;
    i_sb_fwd = '0; i_sb_rev = '0;
    repeat (12) tick();
    chk("rnd_drain_fwd", o_fwd_cnt, 0);
    chk("rnd_drain_rev", o_rev_cnt, 0);

`ifdef CPU_DU_LINK_PARITY_EN
    // ---- parity: corrupt a word sitting in the first stage
    chk("par_idle", o_parity_err, 0);
    i_fwd_ready = 1'b0; i_fwd_valid = 1'b1; i_fwd_data = 32'h1234_5678;
    tick();
    i_fwd_valid = 1'b0;
    ptmp = dut.u_fwd.g_stg[0].u_stg.main_q;
    ptmp[0] = ~ptmp[0];
    force dut.u_fwd.g_stg[0].u_stg.main_q = ptmp;
    tick();
    release dut.u_fwd.g_stg[0].u_stg.main_q;
    chk("par_before_dlv", o_parity_err, 0);
    i_fwd_ready = 1'b1;
    tick();
    chk("par_set", o_parity_err, 1);
    repeat (3) tick();
    chk("par_sticky", o_parity_err, 1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("par_flush_clear", o_parity_err, 0);
`endif

    // ---- asynchronous reset mid-stream
    i_fwd_ready = 1'b0; i_fwd_valid = 1'b1; i_fwd_data = 32'h77; i_sb_fwd = 8'h3C;
    repeat (3) tick();
    chk("arst_pre_valid", o_fwd_valid, 1);
    chk("arst_pre_sb", o_sb_fwd, 8'h3C);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_fwd_ready", o_fwd_ready, 1);
    chk("arst_fwd_valid", o_fwd_valid, 0);
    chk("arst_fwd_cnt", o_fwd_cnt, 0);
    chk("arst_fwd_data", o_fwd_data, 0);
    chk("arst_sb_fwd", o_sb_fwd, 0);
    @(posedge clk);
    #1 i_rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
